// File: rtl/pulse_meter_module.sv
// -----------------------------------------------------------------------------
// pulse_meter_module
//
// Measures the length, in clock cycles, of each high and low phase of a
// square wave (din) that is already in the clk domain, and flags phases whose
// length falls outside EXP_LEN +/- TOL.
//
// Parameters
//   CNT_W   : width of the phase-length counter and of the width result
//   EXP_LEN : expected phase length in clock cycles
//   TOL     : allowed deviation from EXP_LEN in clock cycles
//
// Ports
//   clk         in   single clock, rising edge
//   rst_n       in   synchronous active-low reset (wins over clr and edges)
//   din         in   square wave under measurement
//   clr         in   synchronous clear of measurement state (wins over edges)
//   width       out  length of the phase just completed (holds between strobes)
//   width_lvl   out  din level during the reported phase (holds between strobes)
//   width_valid out  one-cycle strobe: width / width_lvl are new
//   err         out  one-cycle strobe with width_valid: phase out of tolerance
//   err_sticky  out  set by any err, held until clr or reset
//   phase_cnt   out  number of reported phases, modulo 256
//   sq_state    out  FSM state for debug (0 IDLE, 1 HIGH, 2 LOW)
//
// Handshake: width_valid is a pure strobe with no back-pressure. The consumer
// must take width, width_lvl and err in the single cycle width_valid is high;
// width and width_lvl stay stable until the next strobe.
//
// Timing: din is sampled into s1 then s2. An edge is seen while s1 != s2, and
// the FSM acts on it at the following clock, so width_valid rises on the
// second rising edge after din changes. A din phase of L clocks reports L.
// -----------------------------------------------------------------------------
module pulse_meter_module #(
    parameter int CNT_W   = 8,
    parameter int EXP_LEN = 10,
    parameter int TOL     = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             din,
    input  logic             clr,
    output logic [CNT_W-1:0] width,
    output logic             width_lvl,
    output logic             width_valid,
    output logic             err,
    output logic             err_sticky,
    output logic [7:0]       phase_cnt,
    output logic [1:0]       sq_state
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HIGH = 2'd1,
        ST_LOW  = 2'd2
    } state_t;

    // Tolerance window. A negative lower bound is clamped to 0 so the
    // unsigned comparison below never wraps.
    localparam int LO_RAW   = EXP_LEN - TOL;
    localparam int LO_BOUND = (LO_RAW < 0) ? 0 : LO_RAW;
    localparam int HI_BOUND = EXP_LEN + TOL;
    localparam logic [31:0] LO_U = 32'(LO_BOUND);
    localparam logic [31:0] HI_U = 32'(HI_BOUND);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    state_t           state;
    logic             s1;
    logic             s2;
    logic [CNT_W-1:0] cnt;

    logic             edge_seen;
    logic [31:0]      cnt_ext;
    logic             phase_bad;

    assign edge_seen = s1 ^ s2;
    assign cnt_ext   = 32'(cnt);

    // A saturated counter means the true length is unknown and at least
    // CNT_MAX, so it is always reported as an error.
    assign phase_bad = (cnt_ext < LO_U) || (cnt_ext > HI_U) || (cnt == CNT_MAX);

    assign sq_state = state;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            s1          <= 1'b0;
            s2          <= 1'b0;
            cnt         <= '0;
            width       <= '0;
            width_lvl   <= 1'b0;
            width_valid <= 1'b0;
            err         <= 1'b0;
            err_sticky  <= 1'b0;
            phase_cnt   <= 8'd0;
        end else begin
            // The sampler keeps running through clr so that releasing clr
            // never exposes a stale s1/s2 mismatch as a false edge.
            s1 <= din;
            s2 <= s1;

            width_valid <= 1'b0;
            err         <= 1'b0;

            if (clr) begin
                state      <= ST_IDLE;
                cnt        <= '0;
                phase_cnt  <= 8'd0;
                err_sticky <= 1'b0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        // First edge only starts timing; the partial phase
                        // before it has unknown length and is dropped.
                        if (edge_seen) begin
                            state <= s1 ? ST_HIGH : ST_LOW;
                            cnt   <= CNT_ONE;
                        end
                    end

                    ST_HIGH, ST_LOW: begin
                        if (edge_seen) begin
                            width       <= cnt;
                            width_lvl   <= (state == ST_HIGH);
                            width_valid <= 1'b1;
                            err         <= phase_bad;
                            if (phase_bad) begin
                                err_sticky <= 1'b1;
                            end
                            cnt       <= CNT_ONE;
                            state     <= (state == ST_HIGH) ? ST_LOW : ST_HIGH;
                            phase_cnt <= phase_cnt + 8'd1;
                        end else if (cnt != CNT_MAX) begin
                            cnt <= cnt + 1'b1;
                        end
                    end

                    default: begin
                        // Unused encoding: fall back to a clean restart.
                        state <= ST_IDLE;
                        cnt   <= '0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_pulse_meter_module.sv
module tb_pulse_meter_module;

    localparam int CNT_W   = 8;
    localparam int EXP_LEN = 10;
    localparam int TOL     = 1;
    localparam int LO      = (EXP_LEN - TOL < 0) ? 0 : EXP_LEN - TOL;
    localparam int HI      = EXP_LEN + TOL;
    localparam int MAXW    = (1 << CNT_W) - 1;

    // ---------------- clock / reset ----------------
    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             din = 1'b0;
    logic             clr = 1'b0;
    logic [CNT_W-1:0] width;
    logic             width_lvl;
    logic             width_valid;
    logic             err;
    logic             err_sticky;
    logic [7:0]       phase_cnt;
    logic [1:0]       sq_state;

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    pulse_meter_module #(.CNT_W(CNT_W), .EXP_LEN(EXP_LEN), .TOL(TOL)) dut (
        .clk(clk), .rst_n(rst_n), .din(din), .clr(clr),
        .width(width), .width_lvl(width_lvl), .width_valid(width_valid),
        .err(err), .err_sticky(err_sticky), .phase_cnt(phase_cnt),
        .sq_state(sq_state)
    );

    // ---------------- reference model + scoreboard ----------------
    typedef struct {
        logic [7:0] w;
        logic       l;
        logic       e;
        int         due;
        logic [7:0] pc;
        logic       st;
    } rep_t;

    rep_t exp_q[$];

    int         checks = 0;
    int         failures = 0;
    logic       mon_en = 1'b0;
    logic       m_lvl = 1'b0;   // din level as the block's sampler sees it
    logic       m_armed = 1'b0; // a phase start has been observed
    int         m_len = 0;      // clocks spent in the current level
    logic [7:0] m_pc = 8'd0;
    logic       m_st = 1'b0;
    logic [7:0] hold_w = 8'd0;
    logic       hold_l = 1'b0;

    // One din value per clock. A level change closes the current phase; it
    // is reported two clocks later unless it was the first phase after
    // reset/clr, whose start was never seen.
    task automatic step(input logic v);
        rep_t r;
        int   w;
        if (v !== m_lvl) begin
            if (m_armed) begin
                w    = (m_len > MAXW) ? MAXW : m_len;
                r.w  = 8'(w);
                r.l  = m_lvl;
                r.e  = (w < LO) || (w > HI) || (m_len >= MAXW);
                r.due = cyc + 2;
                m_pc = m_pc + 8'd1;
                r.pc = m_pc;
                m_st = m_st | r.e;
                r.st = m_st;
                exp_q.push_back(r);
            end
            m_armed = 1'b1;
            m_lvl   = v;
            m_len   = 1;
        end else begin
            m_len++;
        end
        din = v;
        @(posedge clk);
        #1;
    endtask

    task automatic phase(input logic v, input int n);
        for (int i = 0; i < n; i++) step(v);
    endtask

    // Per-cycle monitor: strobes must appear exactly when due, and width /
    // width_lvl must hold between strobes.
    always @(negedge clk) begin
        if (mon_en) begin
            if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
                rep_t r;
                r = exp_q.pop_front();
                checks++;
                if (width_valid !== 1'b1 || width !== r.w || width_lvl !== r.l ||
                    err !== r.e || phase_cnt !== r.pc || err_sticky !== r.st) begin
                    failures++;
                    $display("FAIL report @%0d: got v=%0b w=%0d l=%0b e=%0b pc=%0d st=%0b want v=1 w=%0d l=%0b e=%0b pc=%0d st=%0b",
                             cyc, width_valid, width, width_lvl, err, phase_cnt, err_sticky,
                             r.w, r.l, r.e, r.pc, r.st);
                end
                hold_w = r.w;
                hold_l = r.l;
            end else begin
                checks++;
                if (width_valid !== 1'b0 || err !== 1'b0) begin
                    failures++;
                    $display("FAIL no_strobe @%0d: got v=%0b e=%0b want v=0 e=0",
                             cyc, width_valid, err);
                end
                checks++;
                if (width !== hold_w || width_lvl !== hold_l) begin
                    failures++;
                    $display("FAIL hold @%0d: got w=%0d l=%0b want w=%0d l=%0b",
                             cyc, width, width_lvl, hold_w, hold_l);
                end
            end
        end
    end

    // ---------------- driver tasks / scenarios ----------------
    task automatic do_reset(input logic v);
        mon_en = 1'b0;
        rst_n  = 1'b0;
        din    = v;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (width !== 8'd0 || width_lvl !== 1'b0 || width_valid !== 1'b0 || err !== 1'b0 ||
            err_sticky !== 1'b0 || phase_cnt !== 8'd0) begin
            failures++;
            $display("FAIL reset_outputs: got w=%0d l=%0b v=%0b e=%0b st=%0b pc=%0d want all 0",
                     width, width_lvl, width_valid, err, err_sticky, phase_cnt);
        end
        checks++;
        if (sq_state !== 2'd0) begin
            failures++;
            $display("FAIL reset_state: got %0d want 0", sq_state);
        end
        exp_q.delete();
        m_lvl   = 1'b0;
        m_armed = 1'b0;
        m_len   = 0;
        m_pc    = 8'd0;
        m_st    = 1'b0;
        hold_w  = 8'd0;
        hold_l  = 1'b0;
        rst_n   = 1'b1;
        mon_en  = 1'b1;
    endtask

    task automatic test_reset();
        do_reset(1'b0);
        phase(1'b0, 4);
        checks++;
        if (sq_state !== 2'd0) begin
            failures++;
            $display("FAIL idle_no_edge: got %0d want 0", sq_state);
        end
    endtask

    task automatic test_steady();
        for (int k = 0; k < 4; k++) begin
            phase(1'b1, 10);
            checks++;
            if (sq_state !== 2'd1) begin
                failures++;
                $display("FAIL state_high: got %0d want 1", sq_state);
            end
            phase(1'b0, 10);
            checks++;
            if (sq_state !== 2'd2) begin
                failures++;
                $display("FAIL state_low: got %0d want 2", sq_state);
            end
        end
    endtask

    task automatic test_latency();
        phase(1'b1, 10);
        step(1'b0);
        checks++;
        if (width_valid !== 1'b0) begin
            failures++;
            $display("FAIL latency_1clk: got %0b want 0", width_valid);
        end
        step(1'b0);
        checks++;
        if (width_valid !== 1'b1) begin
            failures++;
            $display("FAIL latency_2clk: got %0b want 1", width_valid);
        end
        phase(1'b0, 8);
    endtask

    task automatic test_short();
        phase(1'b1, 7);
        phase(1'b0, 10);
        phase(1'b1, 10);
        phase(1'b0, 10);
        checks++;
        if (err_sticky !== 1'b1) begin
            failures++;
            $display("FAIL sticky_held: got %0b want 1", err_sticky);
        end
        phase(1'b1, 10);
        phase(1'b0, 5);
    endtask

    task automatic test_clr();
        checks++;
        if (err_sticky !== 1'b1) begin
            failures++;
            $display("FAIL sticky_before_clr: got %0b want 1", err_sticky);
        end
        // din rises mid-low-phase; clr lands on the clock that would act on it.
        din = 1'b1;
        @(posedge clk);
        #1;
        clr = 1'b1;
        @(posedge clk);
        #1;
        clr = 1'b0;
        checks++;
        if (width_valid !== 1'b0 || phase_cnt !== 8'd0 || err_sticky !== 1'b0 || sq_state !== 2'd0) begin
            failures++;
            $display("FAIL clr_edge: got v=%0b pc=%0d st=%0b fsm=%0d want 0 0 0 0",
                     width_valid, phase_cnt, err_sticky, sq_state);
        end
        m_lvl   = 1'b1;
        m_armed = 1'b0;
        m_len   = 2;
        m_pc    = 8'd0;
        m_st    = 1'b0;
        phase(1'b1, 8);
        checks++;
        if (sq_state !== 2'd0) begin
            failures++;
            $display("FAIL clr_no_false_edge: got %0d want 0", sq_state);
        end
        phase(1'b0, 10);
        phase(1'b1, 10);
        phase(1'b0, 10);
    endtask

    task automatic test_saturate();
        phase(1'b0, 300);
        phase(1'b1, 10);
        phase(1'b0, 5);
    endtask

    task automatic test_random();
        for (int k = 0; k < 40; k++) begin
            int n;
            if ($urandom_range(0, 1) == 0) n = $urandom_range(LO, HI);
            else n = $urandom_range(1, 20);
            phase(~m_lvl, n);
        end
    endtask

    task automatic test_reset_mid();
        phase(1'b1, 10);
        phase(1'b0, 10);
        phase(1'b1, 7);
        phase(1'b0, 5);
        checks++;
        if (err_sticky !== 1'b1) begin
            failures++;
            $display("FAIL sticky_before_reset: got %0b want 1", err_sticky);
        end
        do_reset(1'b0);
        phase(1'b0, 4);
        phase(1'b1, 10);
        phase(1'b0, 10);
        phase(1'b1, 10);
        // Reset while din is high: the release exposes a first edge only.
        do_reset(1'b1);
        phase(1'b1, 6);
        phase(1'b0, 10);
        phase(1'b1, 10);
        phase(1'b0, 4);
    endtask

    task automatic test_drain();
        phase(m_lvl, 5);
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL drain: got %0d pending reports want 0", exp_q.size());
        end
    endtask

    // ---------------- sequence + final report ----------------
    initial begin
        test_reset();
        test_steady();
        test_latency();
        test_short();
        test_clr();
        test_saturate();
        test_random();
        test_reset_mid();
        test_drain();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
